// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with selectable first-word-fall-through output, a fill
// level, programmable almost-full/almost-empty flags and sticky
// overflow/underflow error flags.
//
// Handshake: a write is taken on a rising edge when i_wr_en is high and
// o_full is low. A read is taken on a rising edge when i_rd_en is high and
// o_empty is low. Both flags come from the count register at the start of
// the cycle, so a full FIFO refuses a write even if a read is taken on the
// same edge, and an empty FIFO refuses a read even if a write is taken.
// Refused requests leave pointers, count and memory untouched. They only
// set the matching sticky error flag.
module sync_fifo_flags #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int ADDR_WIDTH = $clog2(FIFO_DEPTH),
    parameter int AF_THRESH  = FIFO_DEPTH - 4,
    parameter int AE_THRESH  = 4,
    parameter bit FWFT       = 1'b0
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_wr_en,
    input  logic [DATA_WIDTH-1:0] i_data_in,
    input  logic                  i_rd_en,
    input  logic                  i_clr_err,
    output logic [DATA_WIDTH-1:0] o_data_out,
    output logic                  o_valid,
    output logic                  o_full,
    output logic                  o_empty,
    output logic                  o_almost_full,
    output logic                  o_almost_empty,
    output logic [ADDR_WIDTH:0]   o_count,
    output logic                  o_overflow,
    output logic                  o_underflow
);

    localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH + 1)'(FIFO_DEPTH);
    localparam logic [ADDR_WIDTH:0] AF_C    = (ADDR_WIDTH + 1)'(AF_THRESH);
    localparam logic [ADDR_WIDTH:0] AE_C    = (ADDR_WIDTH + 1)'(AE_THRESH);

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH:0]   count;
    logic                  full;
    logic                  empty;
    logic                  wr_acc;
    logic                  rd_acc;

    // The status outputs are all decodes of the count register.
    assign full           = (count == DEPTH_C);
    assign empty          = (count == '0);
    assign wr_acc         = i_wr_en && !full;
    assign rd_acc         = i_rd_en && !empty;

    assign o_full         = full;
    assign o_empty        = empty;
    assign o_almost_full  = (count >= AF_C);
    assign o_almost_empty = (count <= AE_C);
    assign o_count        = count;

    // Storage is not reset. Stale words are never shown because reads are
    // gated by the count.
    always_ff @(posedge i_clk) begin
        if (wr_acc) begin
            mem[wr_ptr] <= i_data_in;
        end
    end

    // The pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // The fill level moves only when exactly one side is accepted.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            count <= '0;
        end else begin
            case ({wr_acc, rd_acc})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Sticky error flags. The set term is written last so that it wins over
    // a clear in the same cycle.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_overflow  <= 1'b0;
            o_underflow <= 1'b0;
        end else begin
            if (i_clr_err) begin
                o_overflow  <= 1'b0;
                o_underflow <= 1'b0;
            end
            if (i_wr_en && full) begin
                o_overflow <= 1'b1;
            end
            if (i_rd_en && empty) begin
                o_underflow <= 1'b1;
            end
        end
    end

    generate
        if (FWFT) begin : g_fwft
            // The head word is shown straight from the array. It is forced to
            // zero while empty so that reset and idle output stays defined.
            assign o_data_out = empty ? '0 : mem[rd_ptr];
            assign o_valid    = !empty;
        end else begin : g_std
            logic [DATA_WIDTH-1:0] data_q;
            logic                  valid_q;

            // Registered read. Data is valid for one cycle after each
            // accepted read, and it holds its value otherwise.
            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    data_q  <= '0;
                    valid_q <= 1'b0;
                end else begin
                    valid_q <= rd_acc;
                    if (rd_acc) begin
                        data_q <= mem[rd_ptr];
                    end
                end
            end

            assign o_data_out = data_q;
            assign o_valid    = valid_q;
        end
    endgenerate

endmodule
